video_scale_up_640_480: RTL and testbench

- Read-side counterpart of the 1920x1080 -> 640x480 frame-buffer write path.
- Pops 640x480 RGB888 pixels (packed {8'b0,r,g,b}) from the frame-buffer read FIFO and upscales them by nearest neighbour onto an external display timing (default 1920x1080).
- Horizontal upscale repeats popped pixels. Vertical upscale replays one stored source line from an internal line buffer, so each source pixel is popped exactly once per frame.

---
 rtl/video_scale_pkg.sv | 28 ++
 rtl/video_line_buf.sv | 26 ++
 rtl/video_scale_up_640_480.sv | 184 ++++++++++++++++++
 tb/tb_video_scale_up_640_480.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_scale_pkg.sv
// Shared constants and types for the 640x480 nearest-neighbour upscaler.
package video_scale_pkg;

  localparam int VIN_XRES_DEF  = 640;
  localparam int VIN_YRES_DEF  = 480;
  localparam int VOUT_XRES_DEF = 1920;
  localparam int VOUT_YRES_DEF = 1080;
  localparam int FRAC_BITS     = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [7:0] pad;
    rgb888_t    pix;
  } fifo_word_t;

  // Floor on purpose: keeps the largest source index at vin-1.
  function automatic logic [31:0] calc_step(input int vin, input int vout);
    longint num;
    num = longint'(vin) << FRAC_BITS;
    return 32'(num / longint'(vout));
  endfunction

endpackage

// File: rtl/video_line_buf.sv
// One source line of RGB888: synchronous write, registered read.
module video_line_buf
  import video_scale_pkg::*;
#(
  parameter int DEPTH = VIN_XRES_DEF,
  parameter int AW    = $clog2(VIN_XRES_DEF)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  rgb888_t       wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output rgb888_t       rd_data_o
);

  rgb888_t mem [DEPTH];
  rgb888_t rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_scale_up_640_480.sv
// Nearest-neighbour upscaler: pops source pixels once per frame from a FWFT FIFO
// and replays them onto the display timing. UPSCALE_UNDERFLOW_CNT_EN adds underflow_cnt.
module video_scale_up_640_480
  import video_scale_pkg::*;
#(
  parameter int VIN_XRES  = VIN_XRES_DEF,
  parameter int VIN_YRES  = VIN_YRES_DEF,
  parameter int VOUT_XRES = VOUT_XRES_DEF,
  parameter int VOUT_YRES = VOUT_YRES_DEF
) (
  input  logic        pixclk_in,
  input  logic        rst_in,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic [31:0] rd_data,
  input  logic        fifo_empty,
  output logic        rd_en,
  output logic        pixclk_out,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        underflow
`ifdef UPSCALE_UNDERFLOW_CNT_EN
  , output logic [15:0] underflow_cnt
`endif
);

  localparam int          AW     = $clog2(VIN_XRES);
  localparam logic [31:0] STEP_X = calc_step(VIN_XRES, VOUT_XRES);
  localparam logic [31:0] STEP_Y = calc_step(VIN_YRES, VOUT_YRES);
  localparam logic [15:0] XMAX   = 16'(VIN_XRES);
  localparam logic [15:0] YMAX   = 16'(VIN_YRES);

  logic [31:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [15:0] last_y_q, last_y_d, src_x_prev_q, src_x_prev_d;
  logic        first_line_q, first_line_d, fetch_q, fetch_d;
  logic        de_prev_q, de_prev_d, underflow_q, underflow_d;

  logic [1:0]  de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic        valid1_q, fetch1_q, ufl1_q;
  rgb888_t     pix1_q, pix_out_q, buf_rd, wr_pix;

  logic [15:0] src_x, src_y;
  logic        active, line_start, line_end, fetch_start, fetch_now;
  logic        in_range, new_px, pop_slot;
  logic [AW-1:0] buf_addr;
  fifo_word_t  fifo_w;
  logic        unused_pad;

  assign fifo_w     = rd_data;
  assign unused_pad = ^fifo_w.pad;

  assign src_x       = acc_x_q[31:16];
  assign src_y       = acc_y_q[31:16];
  assign active      = de_in & ~vs_in;
  assign line_start  = active & ~de_prev_q;
  assign line_end    = ~de_in & de_prev_q & ~vs_in;
  // Lines past the last source row replay the buffer without fetching.
  assign fetch_start = (first_line_q | (src_y != last_y_q)) & (src_y < YMAX);
  assign fetch_now   = line_start ? fetch_start : fetch_q;
  assign in_range    = src_x < XMAX;
  assign new_px      = active & (line_start | (src_x != src_x_prev_q)) & in_range;
  assign pop_slot    = fetch_now & new_px;
  assign rd_en       = pop_slot & ~fifo_empty & ~rst_in;
  assign buf_addr    = in_range ? src_x[AW-1:0] : AW'(VIN_XRES - 1);
  assign wr_pix      = fifo_empty ? '0 : fifo_w.pix;

  always_comb begin
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    last_y_d     = last_y_q;
    first_line_d = first_line_q;
    fetch_d      = fetch_q;
    src_x_prev_d = src_x_prev_q;
    underflow_d  = underflow_q;
    de_prev_d    = de_in;
    if (vs_in) begin
      acc_x_d      = '0;
      acc_y_d      = '0;
      first_line_d = 1'b1;
      fetch_d      = 1'b0;
      de_prev_d    = 1'b0;
      underflow_d  = 1'b0;
    end else begin
      if (line_start) begin
        last_y_d     = src_y;
        first_line_d = 1'b0;
        fetch_d      = fetch_start;
      end
      if (active) begin
        acc_x_d      = acc_x_q + STEP_X;
        src_x_prev_d = src_x;
      end
      if (line_end) begin
        acc_x_d = '0;
        acc_y_d = acc_y_q + STEP_Y;
      end
      if (pop_slot && fifo_empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge pixclk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      last_y_q     <= '0;
      first_line_q <= 1'b1;
      fetch_q      <= 1'b0;
      src_x_prev_q <= '0;
      underflow_q  <= 1'b0;
      de_prev_q    <= 1'b0;
    end else begin
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      last_y_q     <= last_y_d;
      first_line_q <= first_line_d;
      fetch_q      <= fetch_d;
      src_x_prev_q <= src_x_prev_d;
      underflow_q  <= underflow_d;
      de_prev_q    <= de_prev_d;
    end
  end

  // Stage 1 holds the fetched pixel (or the buffer read); stage 2 is the output.
  always_ff @(posedge pixclk_in or posedge rst_in) begin
    if (rst_in) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      valid1_q  <= 1'b0;
      fetch1_q  <= 1'b0;
      ufl1_q    <= 1'b0;
      pix1_q    <= '0;
      pix_out_q <= '0;
    end else begin
      de_pipe_q <= {de_pipe_q[0], de_in};
      hs_pipe_q <= {hs_pipe_q[0], hs_in};
      vs_pipe_q <= {vs_pipe_q[0], vs_in};
      valid1_q  <= active;
      fetch1_q  <= fetch_now;
      if (pop_slot) begin
        pix1_q <= wr_pix;
        ufl1_q <= fifo_empty;
      end
      pix_out_q <= valid1_q ? (fetch1_q ? pix1_q : buf_rd) : '0;
    end
  end

  video_line_buf #(.DEPTH(VIN_XRES), .AW(AW)) u_line_buf (
    .clk_i     (pixclk_in),
    .wr_en_i   (pop_slot),
    .wr_addr_i (buf_addr),
    .wr_data_i (wr_pix),
    .rd_addr_i (buf_addr),
    .rd_data_o (buf_rd)
  );

`ifdef UPSCALE_UNDERFLOW_CNT_EN
  logic [15:0] ufl_cnt_q;

  always_ff @(posedge pixclk_in or posedge rst_in) begin
    if (rst_in)                                 ufl_cnt_q <= '0;
    else if (vs_in)                             ufl_cnt_q <= '0;
    else if (valid1_q && fetch1_q && ufl1_q && ufl_cnt_q != 16'hFFFF)
                                                ufl_cnt_q <= ufl_cnt_q + 16'd1;
  end

  assign underflow_cnt = ufl_cnt_q;
`endif

  assign pixclk_out = pixclk_in;
  assign de_out     = de_pipe_q[1];
  assign hs_out     = hs_pipe_q[1];
  assign vs_out     = vs_pipe_q[1];
  assign r_out      = pix_out_q.r;
  assign g_out      = pix_out_q.g;
  assign b_out      = pix_out_q.b;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_video_scale_up_640_480.sv
// Directed/random bench for the upscaler on a reduced 16x6 -> 48x13 geometry.
module tb_video_scale_up_640_480;

  localparam int VX = 16, VY = 6, OX = 48, OY = 13, HBL = 10;
  localparam longint SX = (longint'(VX) << 16) / longint'(OX);
  localparam longint SY = (longint'(VY) << 16) / longint'(OY);

  logic        pixclk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [31:0] rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        rd_en, pixclk_out, vs_out, hs_out, de_out, underflow;
  logic [7:0]  r_out, g_out, b_out;
`ifdef UPSCALE_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int checks = 0, failures = 0;
  int line_pops, exp_pops, frame_pops, black_px;
  logic [31:0] fifo_q [$];
  logic [23:0] img [VY][VX];
  bit          img_ufl [VY][VX];
  logic [2:0]  tim_h [3];
  logic [23:0] pix_h [3];

  always #5 pixclk_in = ~pixclk_in;

  video_scale_up_640_480 #(
    .VIN_XRES(VX), .VIN_YRES(VY), .VOUT_XRES(OX), .VOUT_YRES(OY)
  ) dut (
    .pixclk_in  (pixclk_in),
    .rst_in     (rst_in),
    .vs_in      (vs_in),
    .hs_in      (hs_in),
    .de_in      (de_in),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .pixclk_out (pixclk_out),
    .vs_out     (vs_out),
    .hs_out     (hs_out),
    .de_out     (de_out),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .underflow  (underflow)
`ifdef UPSCALE_UNDERFLOW_CNT_EN
    , .underflow_cnt (underflow_cnt)
`endif
  );

  function automatic int src_x(input int x);
    return int'((longint'(x) * SX) >>> 16);
  endfunction

  function automatic int src_y(input int y);
    return int'((longint'(y) * SY) >>> 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fifo(input bit force_empty);
    fifo_empty = force_empty || (fifo_q.size() == 0);
    rd_data    = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
  endtask

  // One clock: inputs already driven; outputs checked against inputs from two cycles back.
  task automatic tick(input bit exp_rd, input logic [23:0] pix);
    tim_h[2] = tim_h[1]; tim_h[1] = tim_h[0]; tim_h[0] = {de_in, hs_in, vs_in};
    pix_h[2] = pix_h[1]; pix_h[1] = pix_h[0]; pix_h[0] = pix;
    @(negedge pixclk_in);
    check("rd_en", 32'(rd_en), 32'(exp_rd));
    check("timing", 32'({de_out, hs_out, vs_out}), 32'(tim_h[2]));
    check("pixel", 32'({r_out, g_out, b_out}), 32'(pix_h[2]));
    if (rd_en) begin
      line_pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    @(posedge pixclk_in);
    #1;
  endtask

  task automatic blank();
    for (int i = 0; i < HBL; i++) begin
      de_in = 1'b0; vs_in = 1'b0; hs_in = (i >= 2 && i < 6);
      set_fifo(1'b0);
      tick(1'b0, 24'h0);
    end
  endtask

  task automatic vsync_pulse();
    de_in = 1'b0; hs_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vs_in = 1'b1; set_fifo(1'b0); tick(1'b0, 24'h0);
    end
    vs_in = 1'b0;
  endtask

  task automatic reload();
    fifo_q.delete();
    for (int i = 0; i < VX * VY; i++) fifo_q.push_back({8'h00, 24'($urandom)});
    for (int y = 0; y < VY; y++)
      for (int x = 0; x < VX; x++) begin
        img[y][x] = '0; img_ufl[y][x] = 1'b0;
      end
    black_px = 0; frame_pops = 0;
  endtask

  task automatic new_frame();
    vsync_pulse();
    reload();
    check("underflow_after_vs", 32'(underflow), 32'(0));
  endtask

  // Output line y of the current frame; optional forced-empty window, vsync or reset injection.
  task automatic run_line(input int y, input int uf_from, input int uf_len,
                          input int vs_at, input int rst_at);
    int  sy, rsy, sx, psx;
    bit  fetch, newp, emp, erd;
    sy    = src_y(y);
    fetch = (sy < VY) && (y == 0 || sy != src_y(y - 1));
    rsy   = (sy < VY) ? sy : VY - 1;
    line_pops = 0; exp_pops = 0; psx = -1;
    for (int x = 0; x < OX; x++) begin
      if (x == rst_at) begin
        rst_in = 1'b1;
        #1;
        check("rst_outputs", 32'({rd_en, de_out, hs_out, vs_out, underflow, r_out, g_out, b_out}), 32'(0));
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        for (int i = 0; i < 3; i++) begin tim_h[i] = '0; pix_h[i] = '0; end
        repeat (3) tick(1'b0, 24'h0);
        rst_in = 1'b0;
        return;
      end
      if (x == vs_at) begin
        for (int i = 0; i < 2; i++) begin
          de_in = 1'b1; vs_in = 1'b1; hs_in = 1'b0; set_fifo(1'b0);
          tick(1'b0, 24'h0);
        end
        de_in = 1'b0;
        for (int i = 0; i < 2; i++) begin set_fifo(1'b0); tick(1'b0, 24'h0); end
        vs_in = 1'b0;
        return;
      end
      sx   = src_x(x);
      newp = (sx != psx);
      psx  = sx;
      emp  = (x >= uf_from && x < uf_from + uf_len) || (fifo_q.size() == 0);
      de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
      set_fifo(emp);
      erd = fetch && newp && !emp;
      if (fetch && newp) begin
        img[sy][sx]     = emp ? 24'h0 : fifo_q[0][23:0];
        img_ufl[sy][sx] = emp;
      end
      if (fetch && img_ufl[sy][sx]) black_px++;
      if (erd) exp_pops++;
      tick(erd, img[rsy][sx]);
    end
    blank();
    frame_pops += line_pops;
    check("line_pops", 32'(line_pops), 32'(exp_pops));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin tim_h[i] = '0; pix_h[i] = '0; end
    repeat (3) tick(1'b0, 24'h0);
    check("reset_underflow", 32'(underflow), 32'(0));
    check("pixclk_out", 32'(pixclk_out), 32'(pixclk_in));
    rst_in = 1'b0;
    #1;

    // Clean frame with two surplus output lines.
    new_frame();
    for (int y = 0; y < OY + 2; y++) begin
      run_line(y, 0, 0, -1, -1);
      if (y == 0 || y == 3) check("fetch_line_pops", 32'(line_pops), 32'(VX));
      if (y == 1 || y == 2 || y >= OY) check("replay_line_pops", 32'(line_pops), 32'(0));
    end
    check("frame_pops", 32'(frame_pops), 32'(VX * VY));
    check("underflow_clean", 32'(underflow), 32'(0));

    // FIFO forced empty for 10 cycles mid fetch line 0.
    new_frame();
    for (int y = 0; y < 5; y++) run_line(y, 9, (y == 0) ? 10 : 0, -1, -1);
    check("underflow_sticky", 32'(underflow), 32'(1));
`ifdef UPSCALE_UNDERFLOW_CNT_EN
    check("underflow_cnt", 32'(underflow_cnt), 32'(black_px));
`endif

    // vsync mid-line restarts the frame from source row 0.
    new_frame();
    for (int y = 0; y < 4; y++) run_line(y, 0, 0, -1, -1);
    run_line(4, 0, 0, 20, -1);
    reload();
    for (int y = 0; y < 3; y++) begin
      run_line(y, 0, 0, -1, -1);
      if (y == 0) check("restart_pops", 32'(line_pops), 32'(VX));
    end

    // Reset mid-frame, then resynchronise on the next vsync.
    new_frame();
    for (int y = 0; y < 7; y++) run_line(y, 0, 0, -1, -1);
    run_line(7, 0, 0, -1, 30);
    new_frame();
    for (int y = 0; y < 4; y++) begin
      run_line(y, 0, 0, -1, -1);
      if (y == 0) check("post_reset_pops", 32'(line_pops), 32'(VX));
    end
    check("post_reset_underflow", 32'(underflow), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
